acorn128_step_ctrl: RTL
=======================

Name: acorn128_step_ctrl

Overview:
Phase sequencer sitting directly upstream of the ACORN-128 state-update datapath. It generates, one step per cycle, the message bit and the ca/cb control bits plus a step enable for every ACORN-128 phase: initialization, associated data, AD padding, encryption, message padding and finalization. It consumes the datapath's combinational keystream bit to produce ciphertext bits and to assemble the 128-bit tag. Bit-serial, one ACORN step per enabled cycle.

Parameters:
LEN_W, 32, width of the ad_len and msg_len bit counts.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
key  input  128  key; key[0] is the first bit consumed
iv  input  128  IV; iv[0] is the first bit consumed
ad_len  input  LEN_W  associated-data length in bits, latched on start
msg_len  input  LEN_W  plaintext length in bits, latched on start
din_bit  input  1  AD or plaintext bit
din_valid  input  1  din_bit valid
din_ready  output  1  high in AD/MSG phases; the bit is consumed when din_valid && din_ready
ks_in  input  1  keystream bit computed from the current datapath state
step_en  output  1  datapath advances one step this cycle
mbit_out  output  1  message bit for this step
ca_out  output  1  ca for this step
cb_out  output  1  cb for this step
ct_bit  output  1  din_bit ^ ks_in
ct_valid  output  1  step_en in MSG phase
phase  output  3  0 IDLE, 1 INIT, 2 AD, 3 ADPAD, 4 MSG, 5 MSGPAD, 6 FINAL, 7 DONE
tag  output  128  tag register
done  output  1  one-cycle pulse on entering DONE

Behaviour:
- Reset (rst_n low, async): phase=IDLE, step counter=0, tag=0. All outputs are 0 except phase=0. Reset mid-operation aborts immediately; no partial tag is retained.
- Control outputs are combinational from phase, step counter and din_*. The step counter (11 bits) and data counter (LEN_W) are registered.
- IDLE: on start, latch key, iv, ad_len and msg_len, then enter INIT with counter=0. start in any other phase is ignored.
- INIT, 1792 steps, step_en=1 every cycle, ca=1, cb=1. mbit at step i:
  - key[i] for i<128
  - iv[i-128] for 128..255
  - key[0]^1 for i=256
  - key[i mod 128] for 257..1791
- AD, ad_len steps: ca=1, cb=1, mbit=din_bit, step_en=din_valid. The counter advances only on a consumed bit. If ad_len=0, skip AD.
- ADPAD, 256 steps, step_en=1: mbit=1 on step 0, else 0. ca=1 for steps 0..127, else 0. cb=1.
- MSG, msg_len steps: ca=1, cb=0, mbit=din_bit, step_en=din_valid, ct_valid=step_en. If msg_len=0, skip MSG.
- MSGPAD, 256 steps, step_en=1: mbit=1 on step 0, else 0. ca=1 for steps 0..127, else 0. cb=0.
- FINAL, 768 steps, step_en=1, mbit=0, ca=1, cb=1. On FINAL steps 640..767, tag[j] <= ks_in with j = step-640.
- DONE: lasts one cycle with done=1, then returns to IDLE. tag holds until the next start (cleared on start) or reset.
- Phase transitions occur on the cycle the last step of a phase is enabled. The next phase's first step is presented on the following cycle, so there are no bubbles except din_valid stalls.
- din_ready=0 outside AD/MSG. din_valid outside AD/MSG is ignored.
- Step totals: 1792 + ad_len + 256 + msg_len + 256 + 768 enabled steps per run.
- Length overflow: ad_len and msg_len are full LEN_W values. The counter compares for equality only; no wrap occurs before the terminal count.

Test Plan:
- key=0, iv=0, ad_len=0, msg_len=0, start -> 3072 step_en cycles. mbit=1 only at INIT step 256, ADPAD step 0 and MSGPAD step 0. done pulses at cycle 3073 after start. phase sequence 1,3,5,6,7,0.
- key=128'h1 (key[0]=1), iv=all-ones -> INIT mbit: step 0=1, steps 1..127=0, steps 128..255=1, step 256=0, step 384=1.
- ad_len=8, msg_len=8, din_valid held 1, din_bit pattern 8'hA5 -> ca/cb=1/1 during AD and 1/0 during MSG. ct_bit equals din_bit^ks_in on 8 ct_valid cycles. Total 3088 steps.
- MSG with din_valid low for 5 cycles mid-stream -> step_en=0, counters and phase held 5 cycles, no ct_valid. Resumes exactly at the next bit.
- ks_in driven 1 only on FINAL steps 640..767 -> tag=all-ones. ks_in=1 only at step 767 -> tag=128'h8000...0.
- rst_n low at INIT step 1000 -> all outputs 0 and phase=0 at once. start asserted mid-INIT is ignored. A new start after reset reruns the full 1792 INIT steps.

Source files
------------

// File: rtl/acorn128_step_ctrl.sv
// ACORN-128 phase sequencer: drives mbit/ca/cb/step_en per step,
// forms ciphertext bits and collects the tag from the keystream.
module acorn128_step_ctrl #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             din_bit,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ks_in,
  output logic             step_en,
  output logic             mbit_out,
  output logic             ca_out,
  output logic             cb_out,
  output logic             ct_bit,
  output logic             ct_valid,
  output logic [2:0]       phase,
  output logic [127:0]     tag,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    AD     = 3'd2,
    ADPAD  = 3'd3,
    MSG    = 3'd4,
    MSGPAD = 3'd5,
    FIN    = 3'd6,
    DONE   = 3'd7
  } phase_t;

  phase_t           ph;
  logic [10:0]      step;
  logic [LEN_W-1:0] dcnt;
  logic [LEN_W-1:0] ad_q;
  logic [LEN_W-1:0] msg_q;
  logic [127:0]     key_q;
  logic [127:0]     iv_q;
  logic             take;
  logic             last_d;
  logic             low_half;

  assign take     = din_valid & din_ready;
  assign last_d   = (dcnt + LEN_W'(1)) == ((ph == AD) ? ad_q : msg_q);
  assign low_half = (step[10:7] == 4'd0);

  assign phase    = ph;
  assign done     = (ph == DONE);
  assign ct_valid = (ph == MSG) & din_valid;
  assign ct_bit   = (ph == MSG) & (din_bit ^ ks_in);

  always_comb begin
    step_en   = 1'b0;
    mbit_out  = 1'b0;
    ca_out    = 1'b0;
    cb_out    = 1'b0;
    din_ready = 1'b0;
    unique case (ph)
      INIT: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
        if (step[10:7] == 4'd1)
          mbit_out = iv_q[step[6:0]];
        else if (step == 11'd256)
          mbit_out = ~key_q[0];
        else
          mbit_out = key_q[step[6:0]];
      end
      AD: begin
        din_ready = 1'b1;
        step_en   = din_valid;
        mbit_out  = din_bit;
        ca_out    = 1'b1;
        cb_out    = 1'b1;
      end
      ADPAD: begin
        step_en  = 1'b1;
        mbit_out = (step == 11'd0);
        ca_out   = low_half;
        cb_out   = 1'b1;
      end
      MSG: begin
        din_ready = 1'b1;
        step_en   = din_valid;
        mbit_out  = din_bit;
        ca_out    = 1'b1;
      end
      MSGPAD: begin
        step_en  = 1'b1;
        mbit_out = (step == 11'd0);
        ca_out   = low_half;
      end
      FIN: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= IDLE;
      step  <= '0;
      dcnt  <= '0;
      ad_q  <= '0;
      msg_q <= '0;
      key_q <= '0;
      iv_q  <= '0;
      tag   <= '0;
    end else begin
      unique case (ph)
        IDLE: if (start) begin
          key_q <= key;
          iv_q  <= iv;
          ad_q  <= ad_len;
          msg_q <= msg_len;
          tag   <= '0;
          step  <= '0;
          dcnt  <= '0;
          ph    <= INIT;
        end
        INIT: if (step == 11'd1791) begin
          step <= '0;
          ph   <= (ad_q != '0) ? AD : ADPAD;
        end else begin
          step <= step + 11'd1;
        end
        AD: if (take) begin
          if (last_d) begin
            dcnt <= '0;
            ph   <= ADPAD;
          end else begin
            dcnt <= dcnt + LEN_W'(1);
          end
        end
        ADPAD: if (step == 11'd255) begin
          step <= '0;
          ph   <= (msg_q != '0) ? MSG : MSGPAD;
        end else begin
          step <= step + 11'd1;
        end
        MSG: if (take) begin
          if (last_d) begin
            dcnt <= '0;
            ph   <= MSGPAD;
          end else begin
            dcnt <= dcnt + LEN_W'(1);
          end
        end
        MSGPAD: if (step == 11'd255) begin
          step <= '0;
          ph   <= FIN;
        end else begin
          step <= step + 11'd1;
        end
        FIN: begin
          // steps 640..767 are 5*128 + j, so the low 7 bits index the tag
          if (step[10:7] == 4'd5)
            tag[step[6:0]] <= ks_in;
          if (step == 11'd767) begin
            step <= '0;
            ph   <= DONE;
          end else begin
            step <= step + 11'd1;
          end
        end
        DONE: ph <= IDLE;
        default: ph <= IDLE;
      endcase
    end
  end

endmodule
